// File: rtl/jpeg_dec_pkg.sv
// Shared types and constants for the JPEG entropy-coded-segment bit reader.
package jpeg_dec_pkg;

   // Default bit-window width of the reader.
   localparam int WIN_W_DEF = 32;

   // Marker prefix and the stuffing byte that follows a data 0xFF.
   localparam logic [7:0] MRK_PREFIX = 8'hFF;
   localparam logic [7:0] STUFF      = 8'h00;

   // Restart markers and end-of-image.
   localparam logic [7:0] RST0 = 8'hD0;
   localparam logic [7:0] RST1 = 8'hD1;
   localparam logic [7:0] RST2 = 8'hD2;
   localparam logic [7:0] RST3 = 8'hD3;
   localparam logic [7:0] RST4 = 8'hD4;
   localparam logic [7:0] RST5 = 8'hD5;
   localparam logic [7:0] RST6 = 8'hD6;
   localparam logic [7:0] RST7 = 8'hD7;
   localparam logic [7:0] EOI  = 8'hD9;

   // Byte-classifier states.
   typedef enum logic [1:0] {
      ST_NORMAL  = 2'd0,
      ST_FF_SEEN = 2'd1,
      ST_MARKER  = 2'd2
   } unstuff_state_t;

   // True for RSTn markers; lets a decoder tell a restart from a real end.
   function automatic logic is_rst_marker(input logic [7:0] code);
      return (code >= RST0) && (code <= RST7);
   endfunction

endpackage

// File: rtl/jpeg_unstuff_fsm.sv
// Byte classifier: removes 0xFF00 stuffing and fill bytes, detects markers.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_NORMAL  | plain data; 0xFF moves on without being appended
//   ST_FF_SEEN | previous byte was 0xFF; next byte decides stuff/fill/marker
//   ST_MARKER  | marker captured; input stalled until marker_ack
module jpeg_unstuff_fsm
   import jpeg_dec_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           in_accept,
   input  logic [7:0]     in_byte,
   input  logic           marker_ack,
   output unstuff_state_t state,
   output logic           append_en,
   output logic [7:0]     append_byte,
   output logic           marker_set,
   output logic [7:0]     marker_code
);

   unstuff_state_t r_state;
   unstuff_state_t w_state_next;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_NORMAL;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state and per-byte decisions for the byte accepted this cycle.
   always_comb begin
      w_state_next = r_state;
      append_en    = 1'b0;
      append_byte  = in_byte;
      marker_set   = 1'b0;
      marker_code  = in_byte;
      case (r_state)
         ST_NORMAL: begin
            if (in_accept) begin
               if (in_byte == MRK_PREFIX) begin
                  w_state_next = ST_FF_SEEN;
               end else begin
                  append_en = 1'b1;
               end
            end
         end
         ST_FF_SEEN: begin
            if (in_accept) begin
               if (in_byte == STUFF) begin
                  append_en    = 1'b1;
                  append_byte  = MRK_PREFIX;
                  w_state_next = ST_NORMAL;
               end else if (in_byte == MRK_PREFIX) begin
                  // Fill byte: a run of 0xFF still counts as one prefix.
                  w_state_next = ST_FF_SEEN;
               end else begin
                  marker_set   = 1'b1;
                  w_state_next = ST_MARKER;
               end
            end
         end
         ST_MARKER: begin
            if (marker_ack) begin
               w_state_next = ST_NORMAL;
            end
         end
         default: begin
            w_state_next = ST_NORMAL;
         end
      endcase
   end

   assign state = r_state;

endmodule

// File: rtl/jpeg_bit_reader.sv
// MSB-aligned bit window over an unstuffed JPEG entropy-coded byte stream.
module jpeg_bit_reader
   import jpeg_dec_pkg::*;
#(
   parameter  int WIN_W = WIN_W_DEF,
   localparam int AW    = $clog2(WIN_W + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [7:0]       in_byte,
   output logic             in_ready,
   output logic [WIN_W-1:0] bit_window,
   output logic [AW-1:0]    bits_avail,
   input  logic             consume_valid,
   input  logic [4:0]       consume_len,
   output logic             consume_ready,
   input  logic             align,
   output logic             marker_valid,
   output logic [7:0]       marker_code,
   input  logic             marker_ack
);

   unstuff_state_t   w_state;
   logic             w_append_en;
   logic [7:0]       w_append_byte;
   logic             w_marker_set;
   logic [7:0]       w_marker_code;

   logic [WIN_W-1:0] r_window;
   logic [AW-1:0]    r_bits_avail;
   logic             r_marker_valid;
   logic [7:0]       r_marker_code;

   logic             w_in_ready;
   logic             w_accept;
   logic             w_len_ok;
   logic             w_consume_ready;
   logic [AW-1:0]    w_remove;
   logic [WIN_W-1:0] w_win_shifted;
   logic [AW-1:0]    w_avail_after;
   logic [WIN_W-1:0] w_byte_placed;
   logic [WIN_W-1:0] w_win_next;
   logic [AW-1:0]    w_avail_next;

   jpeg_unstuff_fsm u_unstuff (
      .clk         (clk),
      .rst         (rst),
      .in_accept   (w_accept),
      .in_byte     (in_byte),
      .marker_ack  (marker_ack),
      .state       (w_state),
      .append_en   (w_append_en),
      .append_byte (w_append_byte),
      .marker_set  (w_marker_set),
      .marker_code (w_marker_code)
   );

   // Handshakes look only at registered state; room for a byte is judged
   // before any same-cycle consume so the ready path stays short.
   always_comb begin
      w_in_ready      = (w_state != ST_MARKER) && (r_bits_avail <= AW'(WIN_W - 8));
      w_accept        = in_valid && w_in_ready;
      w_len_ok        = (consume_len != 5'd0) && (consume_len <= 5'd16);
      w_consume_ready = consume_valid && !align && w_len_ok
                        && (AW'(consume_len) <= r_bits_avail);
   end

   // Removal first (align beats consume), then the new byte lands right
   // below the surviving bits.
   always_comb begin
      w_remove = '0;
      if (align) begin
         w_remove = AW'(r_bits_avail[2:0]);
      end else if (w_consume_ready) begin
         w_remove = AW'(consume_len);
      end
      w_win_shifted = r_window << w_remove;
      w_avail_after = r_bits_avail - w_remove;
      w_byte_placed = {w_append_byte, {(WIN_W - 8){1'b0}}} >> w_avail_after;
      w_win_next    = w_win_shifted;
      w_avail_next  = w_avail_after;
      if (w_append_en) begin
         w_win_next   = w_win_shifted | w_byte_placed;
         w_avail_next = w_avail_after + AW'(8);
      end
   end

   // Window and valid-bit count.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_window     <= '0;
         r_bits_avail <= '0;
      end else begin
         r_window     <= w_win_next;
         r_bits_avail <= w_avail_next;
      end
   end

   // Marker hold: set on detection, released by an acknowledge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_marker_valid <= 1'b0;
         r_marker_code  <= 8'h00;
      end else if (w_marker_set) begin
         r_marker_valid <= 1'b1;
         r_marker_code  <= w_marker_code;
      end else if (marker_ack && r_marker_valid) begin
         r_marker_valid <= 1'b0;
      end
   end

   assign in_ready      = w_in_ready;
   assign consume_ready = w_consume_ready;
   assign bit_window    = r_window;
   assign bits_avail    = r_bits_avail;
   assign marker_valid  = r_marker_valid;
   assign marker_code   = r_marker_code;

endmodule

// File: tb/tb_jpeg_bit_reader.sv
// Directed and randomized checks of jpeg_bit_reader against a bit-queue model.
module tb_jpeg_bit_reader;

   localparam int WIN_W = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_byte;
   logic        in_ready;
   logic [31:0] bit_window;
   logic [5:0]  bits_avail;
   logic        consume_valid;
   logic [4:0]  consume_len;
   logic        consume_ready;
   logic        align;
   logic        marker_valid;
   logic [7:0]  marker_code;
   logic        marker_ack;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: stream bits in order, classifier mode, held marker.
   bit         mq[$];
   int         mst;      // 0 plain data, 1 after 0xFF, 2 marker held
   logic [7:0] mcode;
   bit         mvalid;

   jpeg_bit_reader #(.WIN_W(WIN_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_byte       (in_byte),
      .in_ready      (in_ready),
      .bit_window    (bit_window),
      .bits_avail    (bits_avail),
      .consume_valid (consume_valid),
      .consume_len   (consume_len),
      .consume_ready (consume_ready),
      .align         (align),
      .marker_valid  (marker_valid),
      .marker_code   (marker_code),
      .marker_ack    (marker_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_window();
      logic [31:0] w;
      w = '0;
      for (int i = 0; i < mq.size(); i++) w[31-i] = mq[i];
      return w;
   endfunction

   task automatic push_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) mq.push_back(b[i]);
   endtask

   // One clock: drive inputs, check handshakes, advance model, check state.
   task automatic cycle(input logic v, input logic [7:0] b, input logic cv,
                        input logic [4:0] len, input logic al, input logic ack);
      logic exp_ir;
      logic exp_cr;
      int   pre;
      int   k;
      in_valid = v; in_byte = b; consume_valid = cv; consume_len = len;
      align = al; marker_ack = ack;
      #1;
      exp_ir = (mst != 2) && (mq.size() <= WIN_W - 8);
      exp_cr = cv && !al && (len >= 1) && (len <= 16) && (int'(len) <= mq.size());
      chk("in_ready", 32'(in_ready), 32'(exp_ir));
      chk("consume_ready", 32'(consume_ready), 32'(exp_cr));
      pre = mst;
      if (al) begin
         k = mq.size() % 8;
         repeat (k) void'(mq.pop_front());
      end else if (exp_cr) begin
         k = int'(len);
         repeat (k) void'(mq.pop_front());
      end
      if (v && exp_ir) begin
         if (mst == 0) begin
            if (b == 8'hFF) mst = 1;
            else push_byte(b);
         end else if (mst == 1) begin
            if (b == 8'h00) begin
               push_byte(8'hFF);
               mst = 0;
            end else if (b != 8'hFF) begin
               mcode  = b;
               mvalid = 1'b1;
               mst    = 2;
            end
         end
      end
      if (pre == 2 && ack) begin
         mst    = 0;
         mvalid = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("bit_window", bit_window, model_window());
      chk("bits_avail", 32'(bits_avail), 32'(mq.size()));
      chk("marker_valid", 32'(marker_valid), 32'(mvalid));
      chk("marker_code", 32'(marker_code), 32'(mcode));
   endtask

   task automatic idle();
      cycle(1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic send(input logic [7:0] b);
      cycle(1'b1, b, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0; in_byte = 8'h00; consume_valid = 1'b0;
      consume_len = 5'd0; align = 1'b0; marker_ack = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      mq.delete();
      mst = 0; mcode = 8'h00; mvalid = 1'b0;
      chk("rst_window", bit_window, 32'h0);
      chk("rst_avail", 32'(bits_avail), 32'd0);
      chk("rst_mvalid", 32'(marker_valid), 32'd0);
      chk("rst_mcode", 32'(marker_code), 32'h00);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic       v, cv, al, ack;
      logic [7:0] b;
      logic [4:0] len;
      int         r;

      do_reset();
      idle();

      // Three plain bytes.
      send(8'h12); send(8'h34); send(8'h56);
      chk("b3_avail", 32'(bits_avail), 32'd24);
      chk("b3_window", 32'(bit_window[31:8]), 32'h123456);
      chk("b3_ready", 32'(in_ready), 32'd1);
      send(8'h99);
      chk("full_ready", 32'(in_ready), 32'd0);

      // Stuffed 0xFF, then a fill byte before the stuff.
      do_reset();
      send(8'hFF); send(8'h00); send(8'hA5);
      chk("stuff_win", 32'(bit_window[31:16]), 32'hFFA5);
      chk("stuff_avail", 32'(bits_avail), 32'd16);
      do_reset();
      send(8'hFF); send(8'hFF); send(8'h00);
      chk("fill_avail", 32'(bits_avail), 32'd8);
      chk("fill_win", 32'(bit_window[31:24]), 32'hFF);

      // Marker hold, drain while held, release.
      do_reset();
      send(8'hAB); send(8'hFF); send(8'hD3);
      chk("mrk_valid", 32'(marker_valid), 32'd1);
      chk("mrk_code", 32'(marker_code), 32'hD3);
      chk("mrk_ready", 32'(in_ready), 32'd0);
      chk("mrk_avail", 32'(bits_avail), 32'd8);
      cycle(1'b1, 8'h77, 1'b1, 5'd3, 1'b0, 1'b0);
      chk("mrk_c3_avail", 32'(bits_avail), 32'd5);
      cycle(1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0);
      chk("mrk_align_avail", 32'(bits_avail), 32'd0);
      cycle(1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b1);
      chk("mrk_ack_valid", 32'(marker_valid), 32'd0);
      chk("mrk_ack_ready", 32'(in_ready), 32'd1);

      // Ack outside MARKER is ignored; FF_SEEN survives it.
      send(8'hFF);
      cycle(1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b1);
      send(8'h00);
      chk("ack_ign_win", 32'(bit_window[31:24]), 32'hFF);

      // Consume and append in the same cycle.
      do_reset();
      send(8'hC3); send(8'h5A); send(8'h99);
      cycle(1'b1, 8'h0F, 1'b1, 5'd5, 1'b0, 1'b0);
      chk("same_avail", 32'(bits_avail), 32'd27);
      chk("same_byte", 32'(bit_window[12:5]), 32'h0F);

      // Over-long and illegal consume lengths.
      do_reset();
      send(8'hAC);
      cycle(1'b0, 8'h00, 1'b1, 5'd4, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 5'd7, 1'b0, 1'b0);
      chk("long_avail", 32'(bits_avail), 32'd4);
      chk("long_win", 32'(bit_window[31:28]), 32'hC);
      cycle(1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b0);
      chk("zero_avail", 32'(bits_avail), 32'd4);
      send(8'h11); send(8'h22); send(8'h33);
      cycle(1'b0, 8'h00, 1'b1, 5'd17, 1'b0, 1'b0);
      chk("len17_avail", 32'(bits_avail), 32'd28);

      // Reset mid-FF_SEEN and mid-marker.
      do_reset();
      send(8'hFF);
      do_reset();
      send(8'h00);
      chk("rst_ff_avail", 32'(bits_avail), 32'd8);
      chk("rst_ff_win", bit_window, 32'h0);
      do_reset();
      send(8'hAB); send(8'hFF); send(8'hD7);
      do_reset();
      send(8'h00);
      chk("rst_mrk_avail", 32'(bits_avail), 32'd8);

      // Randomized traffic against the model.
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         v = ($urandom_range(0, 3) != 0);
         r = int'($urandom_range(0, 9));
         if (r <= 2)      b = 8'hFF;
         else if (r == 3) b = 8'h00;
         else if (r == 4) b = 8'(8'hD0 + $urandom_range(0, 9));
         else             b = 8'($urandom);
         cv  = ($urandom_range(0, 1) == 1);
         len = 5'($urandom_range(0, 18));
         al  = ($urandom_range(0, 15) == 0);
         ack = (mst == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
         cycle(v, b, cv, len, al, ack);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
